dac_sample_sched: RTL and testbench

DAC_SAMPLE_SCHED -- requirements
Module: dac_sample_sched

---
 rtl/dac_sched_pkg.sv | 14 +
 rtl/key_debounce.sv | 64 ++++++
 rtl/dac_sample_sched.sv | 111 +++++++++++
 tb/tb_dac_sample_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: scheduler state encoding and shared constants for dac_sample_sched.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    START,
    WAIT_DONE
  } sched_state_t;

  localparam int         DATA_W_DEF = 10;
  localparam logic [7:0] OVR_MAX    = 8'd255;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer for an active-low push-button, optional debounce
// (enabled by `define DAC_SCHED_DEBOUNCE_EN); emits a one-cycle pulse per accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic press
);

  logic sync1;
  logic sync2;

  // Flops come out of reset at the released level so no false press is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

`ifdef DAC_SCHED_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [CNT_W-1:0] stable_cnt;
  logic             key_state;
  logic             accept;

  // A new level is accepted on its DEBOUNCE_CYC-th consecutive cycle of disagreement.
  assign accept = (sync2 != key_state) && (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1));
  assign press  = accept & ~sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      key_state  <= 1'b1;
    end else if (sync2 == key_state) begin
      stable_cnt <= '0;
    end else if (accept) begin
      stable_cnt <= '0;
      key_state  <= sync2;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end
`else
  logic key_prev;

  assign press = key_prev & ~sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev <= 1'b1;
    end else begin
      key_prev <= sync2;
    end
  end
`endif

endmodule

// File: rtl/dac_sample_sched.sv
// dac_sample_sched: paces TLC5615 conversions from one of two FIR outputs chosen by a push-button.
// Optional key debounce is enabled with `define DAC_SCHED_DEBOUNCE_EN.
module dac_sample_sched
  import dac_sched_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int SAMPLE_DIV   = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_in,
  input  logic [DATA_W-1:0] src0_data,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              dac_busy,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_start,
  output logic              sel_src,
  output logic [7:0]        overrun_cnt
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  sched_state_t     state;
  sched_state_t     state_next;
  logic [DIV_W-1:0] sample_cnt;
  logic             tick;
  logic             press;
  logic             wait_armed;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key (
    .clk   (clk),
    .reset (reset),
    .key_in(key_in),
    .press (press)
  );

  assign tick = (sample_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_src <= 1'b0;
    end else if (press) begin
      sel_src <= ~sel_src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    dac_start  = 1'b0;
    case (state)
      IDLE:      if (tick) state_next = LATCH;
      LATCH:     state_next = START;
      START: begin
        dac_start  = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: if (wait_armed && !dac_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The first WAIT_DONE cycle ignores dac_busy: the serializer may not have raised it yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_armed <= 1'b0;
    end else if (state == START) begin
      wait_armed <= 1'b0;
    end else if (state == WAIT_DONE) begin
      wait_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_data <= '0;
    end else if (state == LATCH) begin
      dac_data <= sel_src ? src1_data : src0_data;
    end
  end

  // Ticks are never queued: any tick outside IDLE is lost and only counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (tick && (state != IDLE) && (overrun_cnt != OVR_MAX)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dac_sample_sched.sv
// tb_dac_sample_sched: randomized scoreboard bench for dac_sample_sched with a cycle-level
// reference model; the model follows DAC_SCHED_DEBOUNCE_EN the same way the design does.
module tb_dac_sample_sched;

  localparam int DATA_W     = 10;
  localparam int SAMPLE_DIV = 100;
  localparam int DEB_CYC    = 50;
`ifdef DAC_SCHED_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  typedef struct {
    int              cyc;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              key_in = 1'b1;
  logic [DATA_W-1:0] src0_data = 10'h155;
  logic [DATA_W-1:0] src1_data = 10'h2AA;
  logic              dac_busy;
  logic [DATA_W-1:0] dac_data;
  logic              dac_start;
  logic              sel_src;
  logic [7:0]        overrun_cnt;

  int vectors = 0;
  int miscompares = 0;

  // serializer emulator settings
  bit busy_en = 1'b0;
  int busy_len = 0;
  int busy_dly_max = 0;
  int key_low_left = 0;

  // reference model state
  exp_t              exp_q[$];
  int                cyc;
  bit                engaged;
  int                start_cyc;
  bit                latch_pending;
  bit                m_sel;
  int                m_ovr;
  logic [DATA_W-1:0] m_dac;
  logic [2:0]        key_hist;
  bit                last_synced;
  bit                acc_level;
  int                run_len;

  dac_sample_sched #(
    .DATA_W      (DATA_W),
    .SAMPLE_DIV  (SAMPLE_DIV),
    .DEBOUNCE_CYC(DEB_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .src0_data  (src0_data),
    .src1_data  (src1_data),
    .dac_busy   (dac_busy),
    .dac_data   (dac_data),
    .dac_start  (dac_start),
    .sel_src    (sel_src),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    cyc           = 0;
    engaged       = 1'b0;
    start_cyc     = 0;
    latch_pending = 1'b0;
    m_sel         = 1'b0;
    m_ovr         = 0;
    m_dac         = '0;
    key_hist      = 3'b111;
    last_synced   = 1'b1;
    acc_level     = 1'b1;
    run_len       = 0;
  endtask

  // Processes the cycle that just ended; leaves expectations for the cycle now starting.
  task automatic modelStep();
    bit synced;
    bit press_now;
    bit tick;
    key_hist  = {key_hist[1:0], key_in};
    synced    = key_hist[2];
    press_now = 1'b0;
    if (DEB_ON) begin
      run_len     = (synced == last_synced) ? run_len + 1 : 1;
      last_synced = synced;
      if (synced != acc_level && run_len >= DEB_CYC) begin
        acc_level = synced;
        press_now = !synced;
      end
    end else begin
      press_now   = last_synced && !synced;
      last_synced = synced;
    end
    if (latch_pending) begin
      m_dac = m_sel ? src1_data : src0_data;
      exp_q.push_back('{cyc + 1, m_dac});
      latch_pending = 1'b0;
    end
    tick = (cyc % SAMPLE_DIV) == (SAMPLE_DIV - 1);
    if (tick) begin
      if (!engaged) begin
        engaged       = 1'b1;
        start_cyc     = cyc + 2;
        latch_pending = 1'b1;
      end else if (m_ovr < 255) begin
        m_ovr++;
      end
    end
    if (engaged && cyc >= start_cyc + 2 && !dac_busy) engaged = 1'b0;
    if (press_now) m_sel = !m_sel;
    cyc++;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      if (reset) modelReset();
      else modelStep();
    end
  end

  // Monitor: compares outputs every cycle and pops the scoreboard on each dac_start.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("sel_src", sel_src, m_sel);
        checkOutput("overrun_cnt", overrun_cnt, m_ovr);
        checkOutput("dac_data_hold", dac_data, m_dac);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL start_missing: no dac_start, expected one in cycle %0d (now %0d)", exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        if (dac_start) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL start_unexpected: dac_start=1, expected 0 (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            checkOutput("start_cycle", cyc, e.cyc);
            checkOutput("start_data", dac_data, e.data);
          end
        end
      end
    end
  end

  // Serializer emulator: raises dac_busy after each dac_start.
  initial begin
    int d;
    int len;
    dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_start && !reset && busy_en) begin
        @(posedge clk);
        #1;
        d = $urandom_range(busy_dly_max, 0);
        repeat (d) begin
          @(posedge clk);
          #1;
        end
        len = (busy_len >= 0) ? busy_len : int'($urandom_range(60, 1));
        dac_busy = 1'b1;
        repeat (len) begin
          @(posedge clk);
          #1;
        end
        dac_busy = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input bit rnd);
    @(posedge clk);
    #1;
    if (rnd) begin
      src0_data = DATA_W'($urandom);
      src1_data = DATA_W'($urandom);
      if (key_low_left > 0) begin
        key_in = 1'b0;
        key_low_left--;
      end else begin
        key_in = 1'b1;
        if ($urandom_range(49, 0) == 0)
          key_low_left = (DEB_ON && $urandom_range(2, 0) == 0) ? int'($urandom_range(80, 50))
                                                                : int'($urandom_range(3, 1));
      end
    end
  endtask

  task automatic waitStart(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (dac_start) seen = 1'b1;
    end
    checkOutput("wait_dac_start", seen, 1);
  endtask

  task automatic pressKey(input int low_cycles);
    @(posedge clk);
    #1;
    key_in = 1'b0;
    repeat (low_cycles) applyStimulus(1'b0);
    key_in = 1'b1;
  endtask

  initial begin
    int starts;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_dac_data", dac_data, 0);
    checkOutput("reset_dac_start", dac_start, 0);
    checkOutput("reset_sel_src", sel_src, 0);
    checkOutput("reset_overrun", overrun_cnt, 0);
    reset = 1'b0;

    $display("[TB] fixed sources, dac_busy held low");
    repeat (350) applyStimulus(1'b0);

    $display("[TB] random sources, key activity and busy lengths");
    busy_en      = 1'b1;
    busy_len     = -1;
    busy_dly_max = 2;
    for (int i = 0; i < 3000; i++) applyStimulus(1'b1);
    key_low_left = 0;
    key_in       = 1'b1;
    src0_data    = 10'h155;
    src1_data    = 10'h2AA;
    repeat (200) applyStimulus(1'b0);

    $display("[TB] key press during WAIT_DONE");
    busy_len     = 80;
    busy_dly_max = 0;
    waitStart(250);
    pressKey(DEB_ON ? 60 : 1);
    repeat (300) applyStimulus(1'b0);

    $display("[TB] bouncing key press");
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      key_in = i[0];
      applyStimulus(1'b0);
    end
    key_in = 1'b0;
    repeat (50) applyStimulus(1'b0);
    key_in = 1'b1;
    repeat (250) applyStimulus(1'b0);

    $display("[TB] reset during WAIT_DONE");
    waitStart(250);
    repeat (10) applyStimulus(1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_dac_data", dac_data, 0);
    checkOutput("midreset_dac_start", dac_start, 0);
    checkOutput("midreset_sel_src", sel_src, 0);
    checkOutput("midreset_overrun", overrun_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    starts = 0;
    repeat (100) begin
      @(negedge clk);
      if (dac_start) starts++;
    end
    checkOutput("no_start_after_reset", starts, 0);
    waitStart(20);

    $display("[TB] long busy, overrun saturation");
    busy_len = 250;
    repeat (46000) applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("overrun_saturated", overrun_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
